mmio_data_memory: RTL

Parametrised memory-mapped data memory for the 16-bit CPU, replacing the fixed 24K-word array with decoded RAM, screen and keyboard regions. Provides:
- a registered CPU port;
- an independent read-only video port for the display scanner;
- a synchronised keyboard register;
- a hardware screen-fill engine that clears or paints the frame buffer without CPU stores.

Sits between the CPU data bus, the display controller and the keyboard interface.

---
 rtl/mmio_data_memory.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mmio_data_memory.sv
// Memory-mapped data memory: RAM, frame buffer and keyboard register behind one CPU port,
// plus a read-only video port and a hardware screen-fill engine.
module mmio_data_memory #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 15,
    parameter int RAM_WORDS    = 16384,
    parameter int SCREEN_WORDS = 8192,
    parameter int KBD_ADDR     = 24576,
    parameter int VID_AW       = 13
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_cpu_adr,
    input  logic [DATA_W-1:0] i_cpu_din,
    input  logic              i_cpu_we,
    output logic [DATA_W-1:0] o_cpu_dout,
    output logic              o_addr_err,
    output logic              o_wr_drop,
    input  logic [VID_AW-1:0] i_vid_adr,
    output logic [DATA_W-1:0] o_vid_dout,
    input  logic [DATA_W-1:0] i_kb_in,
    input  logic              i_clr_start,
    input  logic [DATA_W-1:0] i_clr_value,
    output logic              o_clr_busy,
    output logic              o_clr_done
);

    localparam int              RAM_AW   = $clog2(RAM_WORDS);
    localparam logic [ADDR_W:0] RAM_LIM  = (ADDR_W + 1)'(RAM_WORDS);
    localparam logic [ADDR_W:0] KBD_LIM  = (ADDR_W + 1)'(KBD_ADDR);
    localparam logic [VID_AW-1:0] LAST_IDX = VID_AW'(SCREEN_WORDS - 1);

    typedef enum logic {StIdle, StFill} fill_state_e;

    logic [DATA_W-1:0] r_ram    [RAM_WORDS];
    logic [DATA_W-1:0] r_screen [SCREEN_WORDS];

    fill_state_e       r_state;
    logic [VID_AW-1:0] r_idx;
    logic [DATA_W-1:0] r_clr_val;
    logic              r_clr_busy;
    logic              r_clr_done;

    logic [DATA_W-1:0] r_kb_meta;
    logic [DATA_W-1:0] r_kb_sync;

    logic [DATA_W-1:0] r_cpu_dout;
    logic [DATA_W-1:0] r_vid_dout;
    logic              r_addr_err;
    logic              r_wr_drop;

    logic [ADDR_W:0]   w_adr_ext;
    logic              w_is_ram;
    logic              w_is_scr;
    logic              w_is_kbd;
    logic              w_unmapped;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [VID_AW-1:0] w_scr_idx;
    logic              w_filling;
    logic              w_ram_we;
    logic              w_cpu_scr_we;

    always_comb begin
        w_adr_ext    = {1'b0, i_cpu_adr};
        w_is_ram     = w_adr_ext < RAM_LIM;
        w_is_scr     = !w_is_ram && (w_adr_ext < KBD_LIM);
        w_is_kbd     = w_adr_ext == KBD_LIM;
        w_unmapped   = !(w_is_ram || w_is_scr || w_is_kbd);
        w_ram_idx    = RAM_AW'(i_cpu_adr);
        w_scr_idx    = VID_AW'(i_cpu_adr - ADDR_W'(RAM_WORDS));
        w_filling    = (r_state == StFill);
        w_ram_we     = i_cpu_we && w_is_ram;
        // The fill engine owns the frame-buffer write port while it runs.
        w_cpu_scr_we = i_cpu_we && w_is_scr && !w_filling;
    end

    // Memory arrays are never cleared; every write is suppressed in the reset cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (w_ram_we) begin
                r_ram[w_ram_idx] <= i_cpu_din;
            end
            if (w_filling) begin
                r_screen[r_idx] <= r_clr_val;
            end else if (w_cpu_scr_we) begin
                r_screen[w_scr_idx] <= i_cpu_din;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cpu_dout <= '0;
            r_vid_dout <= '0;
            r_addr_err <= 1'b0;
            r_wr_drop  <= 1'b0;
        end else begin
            r_vid_dout <= r_screen[i_vid_adr];
            r_addr_err <= w_unmapped;
            r_wr_drop  <= i_cpu_we && w_is_scr && w_filling;
            if (w_is_ram) begin
                r_cpu_dout <= r_ram[w_ram_idx];
            end else if (w_is_scr) begin
                r_cpu_dout <= r_screen[w_scr_idx];
            end else if (w_is_kbd) begin
                r_cpu_dout <= r_kb_sync;
            end else begin
                r_cpu_dout <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_kb_meta <= '0;
            r_kb_sync <= '0;
        end else begin
            r_kb_meta <= i_kb_in;
            r_kb_sync <= r_kb_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_idx      <= '0;
            r_clr_val  <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_clr_start) begin
                        r_clr_val  <= i_clr_value;
                        r_idx      <= '0;
                        r_clr_busy <= 1'b1;
                        r_state    <= StFill;
                    end
                end
                StFill: begin
                    if (r_idx == LAST_IDX) begin
                        r_idx      <= '0;
                        r_clr_busy <= 1'b0;
                        r_clr_done <= 1'b1;
                        r_state    <= StIdle;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_cpu_dout = r_cpu_dout;
    assign o_vid_dout = r_vid_dout;
    assign o_addr_err = r_addr_err;
    assign o_wr_drop  = r_wr_drop;
    assign o_clr_busy = r_clr_busy;
    assign o_clr_done = r_clr_done;

endmodule
